pwm_ramp_ctrl: RTL and testbench

Soft-start/soft-stop duty-cycle controller for the team's 8-bit PWM generator.
- Accepts a target duty and a ramp step through a valid/ready command interface.
- Drives the generator's duty_cycle input, moving it toward the target by one step per PWM period.
- Applies updates only at period boundaries, so the generator never sees a mid-period duty change.

---
 rtl/pwm_ramp_ctrl.sv | 80 ++++++++
 tb/tb_pwm_ramp_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop duty controller for the 8-bit PWM generator.
// Steps duty toward a commanded target once per PWM period.
module pwm_ramp_ctrl #(
    parameter int PERIOD = 256,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    input  logic       enable,
    output logic [7:0] duty_cycle,
    output logic       period_tick,
    output logic       busy,
    output logic       done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RAMP = 1'b1;

    logic [CNT_W-1:0] count;
    logic [0:0]       state;
    logic [7:0]       target;
    logic [7:0]       step;
    logic             up;
    logic [8:0]       diff;
    logic             accept;
    logic             active;

    assign period_tick = (count == CNT_W'(PERIOD - 1));
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state == RAMP);
    assign accept      = cmd_valid && cmd_ready;
    assign active      = (state == RAMP) && period_tick && enable;

    // 9-bit magnitude keeps the final-step test free of wrap.
    assign up   = (target > duty_cycle);
    assign diff = up ? ({1'b0, target} - {1'b0, duty_cycle})
                     : ({1'b0, duty_cycle} - {1'b0, target});

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (period_tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            target     <= '0;
            step       <= '0;
            duty_cycle <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                target <= cmd_target;
                step   <= cmd_step;
                state  <= RAMP;
            end else if (active) begin
                if (step == 8'd0 || diff <= {1'b0, step}) begin
                    duty_cycle <= target;
                    done       <= 1'b1;
                    state      <= IDLE;
                end else if (up) begin
                    duty_cycle <= duty_cycle + step;
                end else begin
                    duty_cycle <= duty_cycle - step;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a 4-cycle period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pwm_ramp_ctrl;

    localparam int PERIOD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_target = '0;
    logic [7:0] cmd_step = '0;
    logic       enable = 1'b1;
    logic [7:0] duty_cycle;
    logic       period_tick;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    pwm_ramp_ctrl #(.PERIOD(PERIOD), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step(cmd_step),
        .enable(enable),
        .duty_cycle(duty_cycle),
        .period_tick(period_tick),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for a tick cycle, then step past the edge that acts on it.
    task automatic tick_obs();
        int n = 0;
        while (period_tick !== 1'b1 && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (period_tick !== 1'b1) begin
            checks++;
            failures++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] t, input logic [7:0] s);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b1;

        // 0 -> 10 step 4
        send(8'd10, 8'd4);
        chk("t1_busy", busy, 1);
        chk("t1_ready", cmd_ready, 0);
        tick_obs();
        chk("t1_d4", duty_cycle, 4);
        chk("t1_nodone", done, 0);
        tick_obs();
        chk("t1_d8", duty_cycle, 8);
        tick_obs();
        chk("t1_d10", duty_cycle, 10);
        chk("t1_done", done, 1);
        chk("t1_busy_lo", busy, 0);
        chk("t1_ready_hi", cmd_ready, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // 10 -> 3 step 4
        send(8'd3, 8'd4);
        tick_obs();
        chk("t2_d6", duty_cycle, 6);
        tick_obs();
        chk("t2_d3", duty_cycle, 3);
        chk("t2_done", done, 1);

        // step 0 jumps directly
        send(8'd200, 8'd0);
        tick_obs();
        chk("t3_jump", duty_cycle, 200);
        chk("t3_jump_done", done, 1);

        // target equals current duty
        send(8'd200, 8'd5);
        chk("t3_eq_busy", busy, 1);
        tick_obs();
        chk("t3_eq_duty", duty_cycle, 200);
        chk("t3_eq_done", done, 1);
        chk("t3_eq_idle", busy, 0);

        // accept on a tick cycle, cmd_valid held during RAMP
        begin
            int n = 0;
            while (period_tick !== 1'b1 && n < 4 * PERIOD) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t4_on_tick", period_tick, 1);
        cmd_valid  = 1'b1;
        cmd_target = 8'd220;
        cmd_step   = 8'd10;
        @(negedge clk);
        chk("t4_no_upd", duty_cycle, 200);
        chk("t4_busy", busy, 1);
        cmd_target = 8'd0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t4_tick2", period_tick, 1);
        chk("t4_hold", duty_cycle, 200);
        @(negedge clk);
        chk("t4_d210", duty_cycle, 210);
        tick_obs();
        cmd_valid = 1'b0;
        chk("t4_d220", duty_cycle, 220);
        chk("t4_done", done, 1);
        @(negedge clk);
        chk("t4_no_reaccept", busy, 0);

        // pause mid-ramp 0 -> 12 step 2
        send(8'd0, 8'd0);
        tick_obs();
        chk("t5_zero", duty_cycle, 0);
        send(8'd12, 8'd2);
        tick_obs();
        chk("t5_d2", duty_cycle, 2);
        tick_obs();
        chk("t5_d4", duty_cycle, 4);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_obs();
            chk("t5_frozen", duty_cycle, 4);
            chk("t5_busy", busy, 1);
        end
        enable = 1'b1;
        tick_obs();
        chk("t5_d6", duty_cycle, 6);
        tick_obs();
        chk("t5_d8", duty_cycle, 8);
        tick_obs();
        chk("t5_d10", duty_cycle, 10);
        tick_obs();
        chk("t5_d12", duty_cycle, 12);
        chk("t5_done", done, 1);

        // reset mid-ramp
        send(8'd100, 8'd10);
        tick_obs();
        chk("t6_d22", duty_cycle, 22);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_duty", duty_cycle, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_tick", period_tick, 0);
        rst = 1'b1;
        send(8'd5, 8'd0);
        chk("t6_accept", busy, 1);
        @(negedge clk);
        chk("t6_cnt2", period_tick, 0);
        @(negedge clk);
        chk("t6_cnt3", period_tick, 1);
        @(negedge clk);
        chk("t6_d5", duty_cycle, 5);
        chk("t6_done5", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
